// File: rtl/controle_servo_360.sv
// Quarter-turn sequencer for a continuous-rotation servo: drives the PWM rotate
// select for N quarter turns, each followed by a settling pause, with abort support.
module controle_servo_360 #(
  parameter int unsigned CICLOS_QUARTO = 50000000,
  parameter int unsigned CICLOS_PAUSA  = 10000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] quartos,
  input  logic       parar,
  output logic       largura,
  output logic       ocupado,
  output logic       pronto,
  output logic       abortado,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    GIRANDO = 3'd1,
    PAUSA   = 3'd2,
    FIM     = 3'd3
  } estado_t;

  localparam logic [31:0] ULTIMO_QUARTO = 32'(CICLOS_QUARTO - 1);
  localparam logic [31:0] ULTIMA_PAUSA  = 32'(CICLOS_PAUSA - 1);

  estado_t     estado, prox_estado;
  logic [31:0] contagem, prox_contagem;
  logic [1:0]  restantes, prox_restantes;
  logic        prox_abortado;

  always_comb begin
    prox_estado    = estado;
    prox_contagem  = contagem;
    prox_restantes = restantes;
    prox_abortado  = abortado;
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          prox_abortado = 1'b0;
          if (quartos != 2'd0) begin
            prox_restantes = quartos;
            prox_contagem  = '0;
            prox_estado    = GIRANDO;
          end else begin
            prox_estado = FIM;
          end
        end
      end
      GIRANDO: begin
        // parar wins over a terminal count landing in the same cycle
        if (parar) begin
          prox_estado    = FIM;
          prox_abortado  = 1'b1;
          prox_restantes = '0;
          prox_contagem  = '0;
        end else if (contagem == ULTIMO_QUARTO) begin
          prox_contagem  = '0;
          prox_restantes = restantes - 2'd1;
          prox_estado    = PAUSA;
        end else begin
          prox_contagem = contagem + 32'd1;
        end
      end
      PAUSA: begin
        if (parar) begin
          prox_estado    = FIM;
          prox_abortado  = 1'b1;
          prox_restantes = '0;
          prox_contagem  = '0;
        end else if (contagem == ULTIMA_PAUSA) begin
          prox_contagem = '0;
          prox_estado   = (restantes != 2'd0) ? GIRANDO : FIM;
        end else begin
          prox_contagem = contagem + 32'd1;
        end
      end
      FIM:     prox_estado = OCIOSO;
      default: prox_estado = OCIOSO;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state itself
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= OCIOSO;
      contagem  <= '0;
      restantes <= '0;
      largura   <= 1'b0;
      pronto    <= 1'b0;
      abortado  <= 1'b0;
    end else begin
      estado    <= prox_estado;
      contagem  <= prox_contagem;
      restantes <= prox_restantes;
      largura   <= (prox_estado == GIRANDO);
      pronto    <= (prox_estado == FIM);
      abortado  <= prox_abortado;
    end
  end

  assign ocupado   = (estado != OCIOSO);
  assign db_estado = estado;

endmodule

// File: tb/tb_controle_servo_360.sv
// Directed bench for controle_servo_360: a timeline model fills a scoreboard queue
// of per-cycle expected outputs, which is popped and compared after every clock edge.
module tb_controle_servo_360;

  localparam int CQ = 4;
  localparam int CP = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [1:0] quartos = 2'd0;
  logic       parar = 1'b0;
  logic       largura, ocupado, pronto, abortado;
  logic [2:0] db_estado;

  controle_servo_360 #(.CICLOS_QUARTO(CQ), .CICLOS_PAUSA(CP)) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .quartos  (quartos),
    .parar    (parar),
    .largura  (largura),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .abortado (abortado),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       largura;
    logic       pronto;
    logic       ocupado;
    logic       abortado;
    logic [2:0] estado;
  } esperado_t;

  esperado_t sb[$];
  int        vectors = 0;
  int        errors = 0;
  logic      last_abort = 1'b0;
  string     fase = "";

  function automatic esperado_t mk(input logic l, input logic p, input logic o,
                                   input logic a, input logic [2:0] s);
    esperado_t e;
    e.largura  = l;
    e.pronto   = p;
    e.ocupado  = o;
    e.abortado = a;
    e.estado   = s;
    return e;
  endfunction

  // One entry per busy cycle; abort_at is the entry during which parar is held (0 = none)
  task automatic push_cmd(input int n, input int abort_at);
    int t;
    bit cut;
    t = 0;
    cut = 0;
    for (int q = 0; q < n && !cut; q++) begin
      for (int i = 0; i < CQ && !cut; i++) begin
        t++;
        sb.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 3'd1));
        if (t == abort_at) cut = 1;
      end
      for (int i = 0; i < CP && !cut; i++) begin
        t++;
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 3'd2));
        if (t == abort_at) cut = 1;
      end
    end
    sb.push_back(mk(1'b0, 1'b1, 1'b1, cut, 3'd3));
  endtask

  task automatic compare(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s/%s observed=%0d expected=%0d", fase, tag, obs, exp);
    end
  endtask

  task automatic check_output();
    esperado_t e;
    if (sb.size() > 0) e = sb.pop_front();
    else e = mk(1'b0, 1'b0, 1'b0, last_abort, 3'd0);
    last_abort = e.abortado;
    compare("largura", {2'b0, largura}, {2'b0, e.largura});
    compare("pronto", {2'b0, pronto}, {2'b0, e.pronto});
    compare("ocupado", {2'b0, ocupado}, {2'b0, e.ocupado});
    compare("abortado", {2'b0, abortado}, {2'b0, e.abortado});
    compare("db_estado", db_estado, e.estado);
  endtask

  task automatic apply_stimulus(input logic ini, input logic [1:0] q, input logic par);
    iniciar = ini;
    quartos = q;
    parar   = par;
    @(posedge clock);
    #1;
    check_output();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 2'd0, 1'b0);
  endtask

  // Reset is applied with start and abort both asserted to show it overrides them
  task automatic do_reset();
    sb.delete();
    last_abort = 1'b0;
    reset = 1'b1;
    apply_stimulus(1'b1, 2'd3, 1'b1);
    reset = 1'b0;
  endtask

  initial begin
    fase = "reset";
    do_reset();
    idle(1);

    fase = "quartos2";
    push_cmd(2, 0);
    apply_stimulus(1'b1, 2'd2, 1'b0);
    idle(14);

    fase = "quartos0";
    push_cmd(0, 0);
    apply_stimulus(1'b1, 2'd0, 1'b0);
    idle(2);

    fase = "abort_giro";
    push_cmd(3, CQ + CP + 2);
    apply_stimulus(1'b1, 2'd3, 1'b0);
    idle(CQ + CP + 1);
    apply_stimulus(1'b0, 2'd0, 1'b1);
    apply_stimulus(1'b0, 2'd0, 1'b1);
    apply_stimulus(1'b0, 2'd0, 1'b1);
    idle(2);

    fase = "reset_idle";
    do_reset();
    idle(1);

    fase = "abort_ultimo";
    push_cmd(1, CQ);
    apply_stimulus(1'b1, 2'd1, 1'b0);
    idle(CQ - 1);
    apply_stimulus(1'b0, 2'd0, 1'b1);
    idle(2);

    fase = "abort_pausa";
    push_cmd(2, CQ + 1);
    apply_stimulus(1'b1, 2'd2, 1'b0);
    idle(CQ);
    apply_stimulus(1'b0, 2'd0, 1'b1);
    idle(2);

    fase = "iniciar_repetido";
    push_cmd(1, 0);
    apply_stimulus(1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 7; i++) apply_stimulus(1'b1, 2'd3, 1'b0);
    idle(2);

    fase = "reset_pausa";
    push_cmd(1, 0);
    apply_stimulus(1'b1, 2'd1, 1'b0);
    idle(CQ);
    do_reset();
    push_cmd(1, 0);
    apply_stimulus(1'b1, 2'd1, 1'b0);
    idle(CQ + CP + 2);

    fase = "fim";
    compare("sb_vazio", 3'(sb.size()), 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/controle_servo_360.md
CONTROLE_SERVO_360 -- requirements
Module: controle_servo_360

Interface
REQ-001 Parameter CICLOS_QUARTO, default 50000000, clock cycles the PWM is enabled for one quarter turn (must be ≥1).
REQ-002 Parameter CICLOS_PAUSA, default 10000000, clock cycles the PWM is held off after each quarter turn (must be ≥1).
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 iniciar  input  1  start request; sampled only in state OCIOSO.
REQ-006 quartos  input  2  number of quarter turns (0-3); sampled together with iniciar.
REQ-007 parar  input  1  abort request; effective in GIRANDO and PAUSA only.
REQ-008 largura  output  1  registered select to the continuous-rotation PWM generator (1 = rotate, 0 = stop).
REQ-009 ocupado  output  1  high whenever the state is not OCIOSO.
REQ-010 pronto  output  1  single-cycle completion pulse.
REQ-011 abortado  output  1  sticky flag; last command ended by parar.
REQ-012 db_estado  output  3  state encoding: OCIOSO=0, GIRANDO=1, PAUSA=2, FIM=3.

Function
REQ-013 The block SHALL implement a four-state FSM: OCIOSO, GIRANDO, PAUSA, FIM.
REQ-014 OCIOSO with iniciar=1 and quartos≠0 SHALL load restantes=quartos, clear contagem and abortado, and enter GIRANDO.
REQ-015 OCIOSO with iniciar=1 and quartos=0 SHALL clear abortado and enter FIM directly; largura stays 0.
REQ-016 In GIRANDO largura SHALL be 1; contagem increments each cycle; at contagem=CICLOS_QUARTO-1 it clears, restantes decrements, and the state goes to PAUSA.
REQ-017 Largura SHALL therefore be high for exactly CICLOS_QUARTO consecutive cycles per quarter turn, beginning the cycle after iniciar is sampled.
REQ-018 In PAUSA largura SHALL be 0; at contagem=CICLOS_PAUSA-1 contagem clears and the state goes to GIRANDO if restantes≠0, else FIM.
REQ-019 FIM SHALL last exactly one cycle with pronto=1 and largura=0, then return to OCIOSO.
REQ-020 parar=1 in GIRANDO or PAUSA SHALL enter FIM next cycle, force largura=0, set abortado=1, and clear restantes and contagem.
REQ-021 When parar and a counter terminal count occur in the same cycle, parar SHALL take priority.
REQ-022 iniciar SHALL be ignored in every state except OCIOSO; no command queuing.
REQ-023 parar in OCIOSO or FIM SHALL have no effect.
REQ-024 contagem SHALL be 32 bits wide and restantes 2 bits wide; neither may wrap during normal operation.
REQ-025 Total busy time for quartos=N≥1 with no abort SHALL be N·(CICLOS_QUARTO+CICLOS_PAUSA)+1 cycles.

Reset
REQ-026 reset=1 at a rising edge SHALL force OCIOSO, contagem=0, restantes=0, largura=0, pronto=0, abortado=0, ocupado=0, db_estado=0, overriding all other inputs.
REQ-027 reset mid-operation SHALL stop rotation (largura=0) on the cycle after the reset edge and SHALL NOT produce pronto.

Verification (CICLOS_QUARTO=4, CICLOS_PAUSA=2)
REQ-028 iniciar pulse with quartos=2 -> largura high 4 cycles, low 2, high 4, low 2; pronto pulses once, 13 cycles after the sampling edge; abortado=0.
REQ-029 iniciar with quartos=0 -> next cycle FIM with pronto=1; largura never rises; ocupado high 1 cycle.
REQ-030 quartos=3 command, parar asserted in the 2nd GIRANDO cycle of the 2nd quarter -> next cycle largura=0, FIM, pronto=1, abortado=1 held until the next accepted iniciar.
REQ-031 parar coincident with the last GIRANDO cycle -> FIM (not PAUSA), abortado=1.
REQ-032 iniciar pulsed repeatedly during a quartos=1 run -> ignored; exactly one pronto, 7 cycles after the first sampled iniciar.
REQ-033 reset asserted during PAUSA -> all outputs reach reset values after that edge; a following quartos=1 command completes normally in 7 cycles.
